// File: rtl/serial_operand_tx.sv
// Purpose: latches a 4-bit operand and shifts it out as a framed, pre-encoded bit-serial stream with its own ser_clk.
// Latency: frame spans 2*WIDTH*CLK_DIV cycles after launch, plus a one-cycle done pulse before returning to IDLE.
// Backpressure: none; start edges that arrive outside IDLE are dropped, not queued.
module serial_operand_tx #(
  parameter int WIDTH   = 4,
  parameter int CLK_DIV = 1
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] PHASE_LAST = 4'(CLK_DIV - 1);
  localparam logic [1:0] BIT_LAST   = 2'(WIDTH - 1);
  localparam logic [3:0] OP_MASK    = 4'((1 << WIDTH) - 1);

  logic       clk;
  logic       rst_n;
  logic [3:0] b_pins;
  logic       start;
  logic       unused_pin;

  assign clk        = io_in[0];
  assign rst_n      = io_in[1];
  assign b_pins     = io_in[5:2];
  assign start      = io_in[6];
  assign unused_pin = io_in[7];

  state_t           state;
  state_t           state_nxt;
  logic             start_q;
  logic [3:0]       phase;
  logic [1:0]       bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] enc;
  logic [3:0]       operand;
  logic             launch;
  logic             phase_end;
  logic             ser_data;
  logic             ser_clk;
  logic             busy;
  logic             done;

  assign launch    = (state == IDLE) && start && !start_q;
  assign phase_end = (phase == PHASE_LAST);

  // Pre-invert bits that will pass an odd number of inverting stages in the receiver; first-sent bit sits in shreg[0].
  always_comb begin
    enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      enc[i] = b_pins[WIDTH-1-i] ^ (((WIDTH - 1 - i) % 2) == 1);
    end
  end

  // Next-state logic and Moore outputs decoded from the current state.
  always_comb begin
    state_nxt = state;
    ser_clk   = 1'b0;
    ser_data  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (launch) state_nxt = SETUP;
      end
      SETUP: begin
        busy     = 1'b1;
        ser_data = shreg[0];
        if (phase_end) state_nxt = STROBE;
      end
      STROBE: begin
        busy     = 1'b1;
        ser_clk  = 1'b1;
        ser_data = shreg[0];
        if (phase_end) state_nxt = (bit_cnt == BIT_LAST) ? DONE : SETUP;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, edge detector, phase/bit counters and the operand/shift registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      start_q <= 1'b0;
      phase   <= 4'd0;
      bit_cnt <= 2'd0;
      shreg   <= '0;
      operand <= 4'd0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
      // Phase counter restarts on every state change so each ser_clk phase is exactly CLK_DIV cycles.
      if ((state_nxt != state) || (state == IDLE)) begin
        phase <= 4'd0;
      end else begin
        phase <= phase + 4'd1;
      end
      if (launch) begin
        shreg   <= enc;
        operand <= b_pins & OP_MASK;
        bit_cnt <= 2'd0;
      end else if ((state == STROBE) && phase_end && (bit_cnt != BIT_LAST)) begin
        // Advance on the falling ser_clk edge so data only moves while ser_clk is low.
        shreg   <= shreg >> 1;
        bit_cnt <= bit_cnt + 2'd1;
      end
    end
  end

  assign io_out = {operand, done, busy, ser_clk, ser_data};

endmodule

// File: doc/serial_operand_tx.md
Name: serial_operand_tx

Overview:
- Parallel-to-serial transmitter that loads the shift-register operand of the serial-in adder tile.
- Latches a 4-bit operand B from pins and emits it as a framed bit-serial stream: ser_data plus a generated ser_clk.
- Pre-encodes each bit for the receiver's alternating-inversion flip-flop chain. After one frame the receiver's register holds exactly B.
- Sits on a TinyTapeout tile; io_out[1:0] wire directly to the receiver's serial-data and serial-clock pins.

Parameters:
- WIDTH, 4, bits per frame. Legal range 1..4; the pin map carries 4 operand bits and uses the low WIDTH of them.
- CLK_DIV, 1, clock cycles per ser_clk phase (low or high). Legal range 1..15.

Ports:
- io_in[0]  input  1  clock; all logic on the rising edge.
- io_in[1]  input  1  rst_n; synchronous, active-low.
- io_in[5:2]  input  4  operand B[3:0]; sampled only on the launch edge.
- io_in[6]  input  1  start; a rising edge seen in IDLE launches a frame.
- io_in[7]  input  1  unused, ignored.
- io_out[0]  output  1  ser_data.
- io_out[1]  output  1  ser_clk; the receiver captures ser_data on its rising edge.
- io_out[2]  output  1  busy.
- io_out[3]  output  1  done; one-cycle pulse.
- io_out[7:4]  output  4  last latched operand B; bits above WIDTH read 0.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, all outputs 0, start_q=0, bit counter 0, phase counter 0, latched operand 0.
  - Reset applied mid-frame aborts the frame immediately. No done pulse is produced.
- Start detection: start_q registers io_in[6] every cycle, including in non-IDLE states. Launch = IDLE & start & ~start_q.
  - Edges occurring outside IDLE are dropped, not queued.
  - Holding start high does not relaunch.
- Encoding: frame bit i (i=0 sent first) = B[WIDTH-1-i] XOR ((WIDTH-1-i) odd).
  - For WIDTH=4 the sequence is ~B3, B2, ~B1, B0.
  - The encoded word is computed at launch and held in a shift register.
- States:
  - IDLE: ser_clk=0, ser_data=0, busy=0.
    - On launch: latch B to io_out[7:4] and the shift register, load bit 0 onto ser_data, bit counter=0, go to SETUP.
  - SETUP: busy=1, ser_clk=0, ser_data = current bit.
    - After CLK_DIV cycles go to STROBE and drive ser_clk=1.
  - STROBE: busy=1, ser_clk=1, ser_data held stable.
    - After CLK_DIV cycles, ser_clk returns to 0.
    - If the bit counter = WIDTH-1: go to DONE.
    - Otherwise: increment the bit counter, shift the next bit onto ser_data, go to SETUP.
  - DONE: busy=0, done=1, ser_data=0, ser_clk=0 for exactly one cycle, then IDLE.
- ser_data only changes while ser_clk=0. Setup and hold versus the ser_clk rising edge are each at least CLK_DIV cycles.
- Timing, CLK_DIV=1, WIDTH=4:
  - Launch at edge E0.
  - ser_clk high after E1, E3, E5, E7.
  - done high after E8, IDLE after E9.
  - Total frame = 2*WIDTH*CLK_DIV + 1 cycles after launch.
- Counters:
  - The phase counter is 4-bit and reloads at each state change.
  - The bit counter is 2-bit. It never wraps in normal operation; reaching WIDTH-1 ends the frame.
- io_out[6:4] bits at and above WIDTH are tied 0.

Test Plan:
- Reset, then B=0xB and a start rising edge, CLK_DIV=1.
  - ser_data sampled at the 4 ser_clk rising edges = 0,0,0,1.
  - busy high for 8 cycles, then done pulses once; io_out[7:4]=0xB.
  - A behavioural model of the receiver chain ends holding 0xB.
- B=0x0: sampled bits = 1,0,1,0. B=0xF: sampled bits = 0,1,0,1. The receiver model holds 0x0 and 0xF respectively.
- Start held high for 30 cycles: exactly one frame and one done pulse.
  - A second start edge issued during STROBE is ignored: no second frame.
- Assert rst_n=0 after the 2nd ser_clk rising edge.
  - Next cycle: all outputs 0, no done pulse.
  - A new start then runs a full correct frame.
- CLK_DIV=3, B=0x6.
  - Each ser_clk phase lasts 3 cycles; done arrives 25 cycles after launch.
  - Bits = 1,1,0,0, with ser_data never changing while ser_clk=1.
- B pins change mid-frame (0x5 to 0xA after launch): the transmitted bits and io_out[7:4] still reflect 0x5.
